// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO, any depth >= 2, with count, flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise r_data is registered.
module sync_fifo_param #(
  parameter int D_WIDTH   = 8,
  parameter int D_DEPTH   = 8,
  parameter int AF_THRESH = D_DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CW = $clog2(D_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_en,
  input  logic [D_WIDTH-1:0] w_data,
  input  logic               r_en,
  output logic [D_WIDTH-1:0] r_data,
  output logic               r_valid,
  output logic               isEmpty,
  output logic               isFull,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic               underflow
);

  localparam int PW = $clog2(D_DEPTH);
  localparam logic [PW-1:0] P_LAST = PW'(D_DEPTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(D_DEPTH);
  localparam logic [CW-1:0] C_AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE   = CW'(AE_THRESH);

  logic [D_WIDTH-1:0] mem [D_DEPTH];
  logic [PW-1:0]      w_ptr;
  logic [PW-1:0]      r_ptr;
  logic               wr_acc;
  logic               rd_acc;

  assign isEmpty      = (count == '0);
  assign isFull       = (count == C_FULL);
  assign almost_full  = (count >= C_AF);
  assign almost_empty = (count <= C_AE);

  assign wr_acc = w_en & ~isFull;
  assign rd_acc = r_en & ~isEmpty;

  // Pointers wrap by compare so depth need not be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= w_en & isFull;
      underflow <= r_en & isEmpty;
      if (wr_acc)
        w_ptr <= (w_ptr == P_LAST) ? '0 : w_ptr + PW'(1);
      if (rd_acc)
        r_ptr <= (r_ptr == P_LAST) ? '0 : r_ptr + PW'(1);
      unique case (1'b1)
        (wr_acc & ~rd_acc): count <= count + CW'(1);
        (rd_acc & ~wr_acc): count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst)
      mem[w_ptr] <= w_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign r_data  = mem[r_ptr];
  assign r_valid = ~isEmpty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_acc;
      if (rd_acc)
        r_data <= mem[r_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed and random traffic against a queue model.
// Covers both read modes; the FWFT build is selected by SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int DP = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0;
  logic [W-1:0]  w_data = '0;
  logic          r_en = 1'b0;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          isEmpty;
  logic          isFull;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] q [$];
  logic [W-1:0] exp_rd = '0;
  logic         exp_rv = 1'b0;
  logic         exp_ovf = 1'b0;
  logic         exp_unf = 1'b0;

  sync_fifo_param #(
    .D_WIDTH(W), .D_DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst),
    .w_en(w_en), .w_data(w_data),
    .r_en(r_en), .r_data(r_data), .r_valid(r_valid),
    .isEmpty(isEmpty), .isFull(isFull),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(isEmpty), 32'(n == 0));
    chk("full", 32'(isFull), 32'(n == DP));
    chk("afull", 32'(almost_full), 32'(n >= AF));
    chk("aempty", 32'(almost_empty), 32'(n <= AE));
    chk("ovf", 32'(overflow), 32'(exp_ovf));
    chk("unf", 32'(underflow), 32'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("rvalid", 32'(r_valid), 32'(n != 0));
    if (n != 0)
      chk("rdata", 32'(r_data), 32'(q[0]));
`else
    chk("rvalid", 32'(r_valid), 32'(exp_rv));
    chk("rdata", 32'(r_data), 32'(exp_rd));
`endif
  endtask

  // One clock with the given request; the model advances from pre-edge state.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    bit full, empty;
    w_en = w;
    w_data = d;
    r_en = r;
    @(posedge clk);
    full  = (q.size() == DP);
    empty = (q.size() == 0);
    exp_ovf = w & full;
    exp_unf = r & empty;
    exp_rv  = 1'b0;
    if (r && !empty) begin
      exp_rd = q.pop_front();
      exp_rv = 1'b1;
    end
    if (w && !full)
      q.push_back(d);
    #1;
    check_all();
  endtask

  initial begin
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(isEmpty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(isFull), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_rvalid", 32'(r_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // fill / drain
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h11 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h60 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'hA0 + i), 1'b0);

    // overflow on full, then simultaneous at full
    step(1'b1, 8'hEE, 1'b0);
    step(1'b1, 8'hEF, 1'b0);
    step(1'b1, 8'hF0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

    // underflow on empty, then simultaneous at empty
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // simultaneous at count 3
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h30 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h40 + i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // async reset mid-operation at count 3
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'hC0 + i), 1'b0);
    w_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    q.delete();
    exp_rd  = '0;
    exp_rv  = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    chk("arst_count", 32'(count), 0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // FWFT show-ahead with no r_en
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // random traffic with shifting bias
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 50) % 3;
      step(($urandom_range(0, 9) < 3 + 2 * bias),
           W'($urandom),
           ($urandom_range(0, 9) < 7 - 2 * bias));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
